// File: rtl/uart_rx_pkg.sv
// Shared UART receive definitions: FSM state encoding, frame bit levels and
// default frame geometry (also used by the downstream parity checker).
package uart_rx_pkg;

   localparam int unsigned DEF_INPUT_DATA_WIDTH = 8;
   localparam int unsigned DEF_CLKS_PER_BIT     = 16;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_e;

endpackage

// File: rtl/rx_bit_timer.sv
// Sample counter for the receive FSM: counts half a bit period after load_half,
// a full bit period after load_zero, and flags the sampling edge with sample_tick.
module rx_bit_timer #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load_zero,
   input  logic load_half,
   output logic sample_tick
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          half_q, half_d;
   logic          tick_s;

   // Next count: loads restart from zero and select the terminal value
   always_comb begin
      tick_s = (cnt_q == (half_q ? HALF_LAST : FULL_LAST));
      cnt_d  = cnt_q;
      half_d = half_q;
      if (load_half) begin
         cnt_d  = {CW{1'b0}};
         half_d = 1'b1;
      end else if (load_zero) begin
         cnt_d  = {CW{1'b0}};
         half_d = 1'b0;
      end else if (tick_s) begin
         cnt_d  = {CW{1'b0}};
      end else begin
         cnt_d  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end
   end

   // Counter state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= {CW{1'b0}};
         half_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         half_q <= half_d;
      end
   end

   assign sample_tick = tick_s;

endmodule

// File: rtl/rx_frame_deserializer.sv
// UART receive front-end: start-bit qualification, LSB-first data shift register,
// parity-stage strobe for the downstream checker and stop-bit framing check.
module rx_frame_deserializer
   import uart_rx_pkg::*;
#(
   parameter int unsigned INPUT_DATA_WIDTH = DEF_INPUT_DATA_WIDTH,
   parameter int unsigned CLKS_PER_BIT     = DEF_CLKS_PER_BIT
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        serial_in_synced,
   output logic [INPUT_DATA_WIDTH-1:0] received_data,
   output logic                        is_parity_stage,
   output logic                        data_valid,
   output logic                        framing_error,
   output logic                        busy
);

   localparam int unsigned W  = INPUT_DATA_WIDTH;
   localparam int unsigned IW = $clog2(W + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

   rx_state_e      state_q, state_d;
   logic [W-1:0]   data_q, data_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic           par_q, par_d;
   logic           dv_q, dv_d;
   logic           fe_q, fe_d;
   logic           busy_q, busy_d;
   logic           load_zero_s, load_half_s, tick_s;

   rx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
      .clk         (clk),
      .rst_n       (reset),
      .load_zero   (load_zero_s),
      .load_half   (load_half_s),
      .sample_tick (tick_s)
   );

   // Frame FSM; strobes default low so they last exactly one cycle
   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      idx_d       = idx_q;
      par_d       = 1'b0;
      dv_d        = 1'b0;
      fe_d        = 1'b0;
      load_zero_s = 1'b0;
      load_half_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (serial_in_synced == START_BIT) begin
               state_d     = ST_START;
               load_half_s = 1'b1;
            end else begin
               load_zero_s = 1'b1;
            end
         end
         ST_START: begin
            if (tick_s) begin
               load_zero_s = 1'b1;
               idx_d       = {IW{1'b0}};
               state_d     = (serial_in_synced == START_BIT) ? ST_DATA : ST_IDLE;
            end else begin
               state_d     = ST_START;
            end
         end
         ST_DATA: begin
            if (tick_s) begin
               data_d = {serial_in_synced, data_q[W-1:1]};
               if (idx_q == LAST_IDX) begin
                  state_d = ST_PARITY;
               end else begin
                  idx_d = idx_q + {{(IW-1){1'b0}}, 1'b1};
               end
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_PARITY: begin
            if (tick_s) begin
               par_d   = 1'b1;
               state_d = ST_STOP;
            end else begin
               state_d = ST_PARITY;
            end
         end
         ST_STOP: begin
            // Leaving at mid-stop lets a back-to-back start edge be caught
            if (tick_s) begin
               state_d = ST_IDLE;
               if (serial_in_synced == STOP_BIT) begin
                  dv_d = 1'b1;
               end else begin
                  fe_d = 1'b1;
               end
            end else begin
               state_d = ST_STOP;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            load_zero_s = 1'b1;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         data_q  <= {W{1'b0}};
         idx_q   <= {IW{1'b0}};
         par_q   <= 1'b0;
         dv_q    <= 1'b0;
         fe_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         idx_q   <= idx_d;
         par_q   <= par_d;
         dv_q    <= dv_d;
         fe_q    <= fe_d;
         busy_q  <= busy_d;
      end
   end

   assign received_data   = data_q;
   assign is_parity_stage = par_q;
   assign data_valid      = dv_q;
   assign framing_error   = fe_q;
   assign busy            = busy_q;

endmodule

// File: tb/tb_rx_frame_deserializer.sv
// Self-checking bench: frames are laid out as per-edge line values, and a
// frame-level model predicts every output after every clock edge.
module tb_rx_frame_deserializer;

   localparam int W    = 8;
   localparam int C    = 16;
   localparam int H    = C / 2;
   localparam int MAXE = 4096;

   logic         clk = 1'b0;
   logic         reset;
   logic         serial_in_synced;
   logic [W-1:0] received_data;
   logic         is_parity_stage;
   logic         data_valid;
   logic         framing_error;
   logic         busy;

   always #5 clk = ~clk;

   rx_frame_deserializer #(.INPUT_DATA_WIDTH(W), .CLKS_PER_BIT(C)) dut (
      .clk              (clk),
      .reset            (reset),
      .serial_in_synced (serial_in_synced),
      .received_data    (received_data),
      .is_parity_stage  (is_parity_stage),
      .data_valid       (data_valid),
      .framing_error    (framing_error),
      .busy             (busy)
   );

   // Index k = value sampled at / expected just after clock edge k of a phase
   bit           line_a   [MAXE];
   bit           exp_par  [MAXE];
   bit           exp_dv   [MAXE];
   bit           exp_fe   [MAXE];
   bit           exp_busy [MAXE];
   bit           upd_v    [MAXE];
   logic [W-1:0] upd_val  [MAXE];
   int           t;
   logic [W-1:0] model_data;
   logic [W-1:0] cur_exp;
   int           n_checks;
   int           n_fail;
   int           dv_edges[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < MAXE; i++) begin
         line_a[i]   = 1'b1;
         exp_par[i]  = 1'b0;
         exp_dv[i]   = 1'b0;
         exp_fe[i]   = 1'b0;
         exp_busy[i] = 1'b0;
         upd_v[i]    = 1'b0;
         upd_val[i]  = '0;
      end
      t = 1;
   endtask

   task automatic build_idle(input int n);
      t += n;
   endtask

   // Line low for L (< = H) cycles: rejected at the mid-start sample
   task automatic build_false(input int L);
      for (int i = 0; i < L; i++) line_a[t+i] = 1'b0;
      for (int i = 0; i < H; i++) exp_busy[t+i] = 1'b1;
      t += H + 1;
   endtask

   task automatic build_frame(input logic [W-1:0] d, input bit par, input bit stop);
      int n0;
      logic [31:0] v;
      n0 = t;
      for (int i = 0; i < C; i++) begin
         line_a[n0+i]       = 1'b0;
         line_a[n0+9*C+i]   = par;
      end
      for (int k = 0; k < W; k++) begin
         for (int i = 0; i < C; i++) line_a[n0+(k+1)*C+i] = d[k];
         // after k+1 samples the first k+1 data bits occupy the top of the word
         v = ((32'(model_data) >> (k+1)) | (32'(d) << (W-1-k))) & ((32'd1 << W) - 32'd1);
         upd_v[n0+H+(k+1)*C]   = 1'b1;
         upd_val[n0+H+(k+1)*C] = v[W-1:0];
      end
      model_data = d;
      for (int i = 0; i < H + 10*C; i++) exp_busy[n0+i] = 1'b1;
      exp_par[n0+H+9*C] = 1'b1;
      if (stop) begin
         exp_dv[n0+H+10*C] = 1'b1;
      end else begin
         exp_fe[n0+H+10*C] = 1'b1;
         for (int i = 0; i <= H; i++) line_a[n0+10*C+i] = 1'b0;
      end
      t = n0 + 11*C;
   endtask

   task automatic check_edge(input int k);
      if (upd_v[k]) cur_exp = upd_val[k];
      chk($sformatf("data@%0d", k), received_data, cur_exp);
      chk($sformatf("par@%0d", k), is_parity_stage, exp_par[k]);
      chk($sformatf("dv@%0d", k), data_valid, exp_dv[k]);
      chk($sformatf("fe@%0d", k), framing_error, exp_fe[k]);
      chk($sformatf("busy@%0d", k), busy, exp_busy[k]);
      if (data_valid === 1'b1) dv_edges.push_back(k);
   endtask

   // Called at a negedge; drives the line half a period before each edge
   task automatic run_phase(input int last);
      for (int k = 1; k <= last && k < MAXE; k++) begin
         serial_in_synced = line_a[k];
         @(posedge clk);
         @(negedge clk);
         check_edge(k);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_data"}, received_data, 32'h0);
      chk({tag, "_par"},  is_parity_stage, 32'h0);
      chk({tag, "_dv"},   data_valid, 32'h0);
      chk({tag, "_fe"},   framing_error, 32'h0);
      chk({tag, "_busy"}, busy, 32'h0);
   endtask

   initial begin
      int n0;
      int spacing;
      logic [W-1:0] d;
      n_checks         = 0;
      n_fail           = 0;
      cur_exp          = '0;
      model_data       = '0;
      reset            = 1'b0;
      serial_in_synced = 1'b1;
      repeat (2) @(negedge clk);
      chk_all_zero("rst");
      reset = 1'b1;

      // Directed frames: A5, false start, stop-bit error, back-to-back, bad parity
      clear_model();
      build_idle(3);
      build_frame(8'hA5, 1'b0, 1'b1);
      build_idle(5);
      build_false(4);
      build_idle(6);
      build_frame(8'h3C, 1'b0, 1'b0);
      build_idle(4);
      build_frame(8'h00, 1'b0, 1'b1);
      build_frame(8'hFF, 1'b0, 1'b1);
      build_idle(4);
      build_frame(8'h01, 1'b0, 1'b1);
      build_idle(10);
      dv_edges.delete();
      run_phase(t);
      chk("dv_count", dv_edges.size(), 32'd4);
      // start + W data + parity + stop bits per back-to-back frame
      spacing = (dv_edges.size() >= 3) ? dv_edges[2] - dv_edges[1] : -1;
      chk("b2b_spacing", spacing, 11*C);

      // Reset in the middle of the data bits
      clear_model();
      build_idle(2);
      n0 = t;
      build_frame(8'h77, 1'b1, 1'b1);
      run_phase(n0 + 80);
      reset = 1'b0;
      #1;
      chk_all_zero("async_rst");
      @(posedge clk);
      @(negedge clk);
      chk_all_zero("held_rst");
      reset      = 1'b1;
      cur_exp    = '0;
      model_data = '0;

      // Clean frame after reset, then randomized frames and gaps
      clear_model();
      build_idle(2);
      build_frame(8'h5A, 1'b0, 1'b1);
      for (int f = 0; f < 8; f++) begin
         d = W'($urandom);
         build_frame(d, ($urandom_range(0, 3) == 0) ? ~^d : ^d, $urandom_range(0, 3) != 0);
         if ($urandom_range(0, 3) == 0) begin
            build_idle($urandom_range(1, 5));
            build_false($urandom_range(1, H));
         end
         if ($urandom_range(0, 2) != 0) build_idle($urandom_range(1, 20));
      end
      build_idle(10);
      run_phase(t);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
